// File: rtl/bcd_pkg.sv
// Shared BCD constants and the seven-segment decode used by the scanned BCD counter.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Segment order is {a,b,c,d,e,f,g}, active-high; anything outside 0..9 blanks.
    function automatic logic [6:0] seg7_of(input logic [BCD_W-1:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1111110;
            4'd1:    pattern = 7'b0110000;
            4'd2:    pattern = 7'b1101101;
            4'd3:    pattern = 7'b1111001;
            4'd4:    pattern = 7'b0110011;
            4'd5:    pattern = 7'b1011011;
            4'd6:    pattern = 7'b1011111;
            4'd7:    pattern = 7'b1110000;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1111011;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: loadable (with >9 folding), up/down, chained via en and term.
module bcd_decade
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             cr,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    input  logic             en,
    input  logic             up,
    output logic [BCD_W-1:0] q,
    output logic             term,
    output logic             bad
);

    assign bad  = (d > BCD_MAX);
    assign term = up ? (q == BCD_MAX) : (q == BCD_MIN);

    // Out-of-range load values fold down by ten so q is always a legal BCD digit.
    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            q <= BCD_MIN;
        end else if (!ld) begin
            q <= bad ? (d - 4'd10) : d;
        end else if (en) begin
            if (up) begin
                q <= term ? BCD_MIN : (q + 4'd1);
            end else begin
                q <= term ? BCD_MAX : (q - 4'd1);
            end
        end
    end

endmodule

// File: rtl/bcd_updown_scan_counter.sv
// Multi-decade BCD up/down counter with cascade enables and a scanned 7-segment display.
module bcd_updown_scan_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                    clk,
    input  logic                    cr,
    input  logic                    ld,
    input  logic [BCD_W*DIGITS-1:0] din,
    input  logic                    ep,
    input  logic                    et,
    input  logic                    up,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                    rco,
    output logic                    ld_err,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       sel
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0] chain;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] bad;
    logic [DIV_W-1:0]  div;
    logic [PTR_W-1:0]  ptr;
    logic [BCD_W-1:0]  shown;

    assign chain[0] = ep & et;

    // Decade i counts only when every lower decade sits at its terminal value.
    for (genvar i = 0; i < DIGITS; i++) begin : g_decade
        bcd_decade u_decade (
            .clk  (clk),
            .cr   (cr),
            .ld   (ld),
            .d    (din[i*BCD_W +: BCD_W]),
            .en   (chain[i]),
            .up   (up),
            .q    (q[i*BCD_W +: BCD_W]),
            .term (term[i]),
            .bad  (bad[i])
        );
        if (i < DIGITS - 1) begin : g_link
            assign chain[i+1] = chain[i] & term[i];
        end
    end

    assign rco = et & (&term);

    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            ld_err <= 1'b0;
        end else begin
            ld_err <= ~ld & (|bad);
        end
    end

    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            div <= '0;
            ptr <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            ptr <= (ptr == PTR_W'(DIGITS - 1)) ? '0 : ptr + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        shown = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ptr == PTR_W'(i)) begin
                shown = q[i*BCD_W +: BCD_W];
            end
        end
    end

    // The display trails the pointer and count by one clock.
    always_ff @(posedge clk or posedge cr) begin
        if (cr) begin
            sel <= ~DIGITS'(1);
            seg <= 7'b1111110;
        end else begin
            sel <= ~(DIGITS'(1) << ptr);
            seg <= seg7_of(shown);
        end
    end

endmodule

// File: tb/tb_bcd_updown_scan_counter.sv
// Randomized bench for bcd_updown_scan_counter against a decimal-arithmetic reference model.
module tb_bcd_updown_scan_counter;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int DW       = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          cr;
    logic          ld;
    logic [DW-1:0] din;
    logic          ep;
    logic          et;
    logic          up;
    logic [DW-1:0] q;
    logic          rco;
    logic          ld_err;
    logic [6:0]    seg;
    logic [DIGITS-1:0] sel;

    int check_count = 0;
    int pass_count  = 0;
    int modulus;
    int model_val;
    int model_edges;

    logic [6:0] seg_table [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    bcd_updown_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .cr     (cr),
        .ld     (ld),
        .din    (din),
        .ep     (ep),
        .et     (et),
        .up     (up),
        .q      (q),
        .rco    (rco),
        .ld_err (ld_err),
        .seg    (seg),
        .sel    (sel)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input int val, input int idx);
        return (val / pow10(idx)) % 10;
    endfunction

    function automatic logic [DW-1:0] to_bcd(input int val);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'(digit_of(val, i));
        return r;
    endfunction

    function automatic int fold_val(input logic [DW-1:0] d);
        int r = 0;
        int nib;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(d[i*4 +: 4]);
            if (nib > 9) nib = nib - 10;
            r = r + nib * pow10(i);
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [DW-1:0] d);
        logic r = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (int'(d[i*4 +: 4]) > 9) r = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Called at a falling edge; drives one cycle, advances the model at the rising edge and checks.
    task automatic applyStimulus(input logic ld_i, input logic [DW-1:0] din_i,
                                 input logic ep_i, input logic et_i, input logic up_i);
        int prev_val;
        int prev_ptr;
        logic exp_err;
        logic exp_rco;
        logic [DIGITS-1:0] exp_sel;
        ld  = ld_i;
        din = din_i;
        ep  = ep_i;
        et  = et_i;
        up  = up_i;
        #1;
        exp_rco = et_i && (up_i ? (model_val == modulus - 1) : (model_val == 0));
        checkOutput("rco", 32'(rco), 32'(exp_rco));
        @(posedge clk);
        prev_val = model_val;
        prev_ptr = (model_edges / SCAN_DIV) % DIGITS;
        exp_err  = 1'b0;
        if (!ld_i) begin
            model_val = fold_val(din_i);
            exp_err   = any_bad(din_i);
        end else if (ep_i && et_i) begin
            model_val = up_i ? (model_val + 1) % modulus : (model_val + modulus - 1) % modulus;
        end
        model_edges++;
        exp_sel = '1;
        exp_sel[prev_ptr] = 1'b0;
        #1;
        checkOutput("q", 32'(q), 32'(to_bcd(model_val)));
        checkOutput("ld_err", 32'(ld_err), 32'(exp_err));
        checkOutput("sel", 32'(sel), 32'(exp_sel));
        checkOutput("seg", 32'(seg), 32'(seg_table[digit_of(prev_val, prev_ptr)]));
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts cr between clock edges and checks the immediate reset state.
    task automatic pulseReset();
        logic [DIGITS-1:0] exp_sel;
        #2 cr = 1'b1;
        #1;
        exp_sel = '1;
        exp_sel[0] = 1'b0;
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'(exp_sel));
        checkOutput("rst_seg", 32'(seg), 32'(7'b1111110));
        checkOutput("rst_ld_err", 32'(ld_err), 32'd0);
        checkOutput("rst_rco", 32'(rco), 32'(et & ~up));
        model_val   = 0;
        model_edges = 0;
        @(negedge clk);
        cr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rnd_din;
        modulus     = pow10(DIGITS);
        model_val   = 0;
        model_edges = 0;
        cr  = 1'b1;
        ld  = 1'b1;
        din = '0;
        ep  = 1'b0;
        et  = 1'b1;
        up  = 1'b0;
        #3;
        checkOutput("init_q", 32'(q), 32'd0);
        checkOutput("init_rco", 32'(rco), 32'd1);
        checkOutput("init_seg", 32'(seg), 32'(7'b1111110));
        @(negedge clk);
        cr = 1'b0;

        applyStimulus(1'b0, 8'h98, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h45, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'hFA, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h50, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
            applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 8'h99, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h27, 1'b0, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        pulseReset();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                pulseReset();
            end else begin
                if ($urandom_range(0, 3) == 0) rnd_din = DW'($urandom);
                else rnd_din = to_bcd(int'($urandom_range(0, modulus - 1)));
                applyStimulus($urandom_range(0, 9) != 0, rnd_din,
                              $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                              1'($urandom));
            end
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
